// File: rtl/enum_cast_checker.sv
// Registered $cast-style validation of a signed integer stream onto {TEN, ELEVEN, SIXTEEN},
// with a one-deep valid/ready output register, saturating statistics and first-fail capture.
module enum_cast_checker #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_ok,
  output logic [4:0]              out_enum,
  output logic [CNT_W-1:0]        ok_count,
  output logic [CNT_W-1:0]        fail_count,
  output logic                    first_fail_valid,
  output logic [WIDTH-1:0]        first_fail_data
);

  typedef enum logic [4:0] {
    TEN     = 5'd10,
    ELEVEN  = 5'd11,
    SIXTEEN = 5'd16
  } cast_e;

  localparam logic signed [WIDTH-1:0] TEN_W     = WIDTH'(10);
  localparam logic signed [WIDTH-1:0] ELEVEN_W  = WIDTH'(11);
  localparam logic signed [WIDTH-1:0] SIXTEEN_W = WIDTH'(16);

  logic             out_valid_q, out_valid_d;
  logic             out_ok_q, out_ok_d;
  cast_e            enum_q, enum_d;
  logic [CNT_W-1:0] ok_count_q, ok_count_d;
  logic [CNT_W-1:0] fail_count_q, fail_count_d;
  logic             ff_valid_q, ff_valid_d;
  logic [WIDTH-1:0] ff_data_q, ff_data_d;

  logic  accept;
  logic  legal;
  cast_e cast_val;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Full-width compares; an X/Z word falls through to the illegal default.
  always_comb begin
    legal    = 1'b0;
    cast_val = enum_q;
    if (in_data == TEN_W) begin
      legal    = 1'b1;
      cast_val = TEN;
    end else if (in_data == ELEVEN_W) begin
      legal    = 1'b1;
      cast_val = ELEVEN;
    end else if (in_data == SIXTEEN_W) begin
      legal    = 1'b1;
      cast_val = SIXTEEN;
    end
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_ok_d     = out_ok_q;
    enum_d       = enum_q;
    ok_count_d   = ok_count_q;
    fail_count_d = fail_count_q;
    ff_valid_d   = ff_valid_q;
    ff_data_d    = ff_data_q;

    if (accept) begin
      out_valid_d = 1'b1;
      out_ok_d    = legal;
      enum_d      = cast_val;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // Clear outranks a same-cycle accept: that item is neither counted nor captured.
    if (clear) begin
      ok_count_d   = '0;
      fail_count_d = '0;
      ff_valid_d   = 1'b0;
    end else if (accept) begin
      if (legal) begin
        if (ok_count_q != '1) ok_count_d = ok_count_q + 1'b1;
      end else begin
        if (fail_count_q != '1) fail_count_d = fail_count_q + 1'b1;
        if (!ff_valid_q) begin
          ff_valid_d = 1'b1;
          ff_data_d  = in_data;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_ok_q     <= 1'b0;
      enum_q       <= SIXTEEN;
      ok_count_q   <= '0;
      fail_count_q <= '0;
      ff_valid_q   <= 1'b0;
      ff_data_q    <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_ok_q     <= out_ok_d;
      enum_q       <= enum_d;
      ok_count_q   <= ok_count_d;
      fail_count_q <= fail_count_d;
      ff_valid_q   <= ff_valid_d;
      ff_data_q    <= ff_data_d;
    end
  end

  assign out_valid        = out_valid_q;
  assign out_ok           = out_ok_q;
  assign out_enum         = enum_q;
  assign ok_count         = ok_count_q;
  assign fail_count       = fail_count_q;
  assign first_fail_valid = ff_valid_q;
  assign first_fail_data  = ff_data_q;

endmodule

// File: tb/tb_enum_cast_checker.sv
// Scoreboard bench for enum_cast_checker: the driver pushes expected results at accept time,
// a negedge monitor pops and compares whenever a result is consumed.
module tb_enum_cast_checker;

  localparam int WIDTH = 32;
  localparam int CW    = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             clear = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic signed [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             out_ok;
  logic [4:0]       out_enum;
  logic [CW-1:0]    ok_count;
  logic [CW-1:0]    fail_count;
  logic             first_fail_valid;
  logic [WIDTH-1:0] first_fail_data;

  enum_cast_checker #(.WIDTH(WIDTH), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ok(out_ok), .out_enum(out_enum),
    .ok_count(ok_count), .fail_count(fail_count),
    .first_fail_valid(first_fail_valid), .first_fail_data(first_fail_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             ok;
    logic [4:0]       en;
    logic [CW-1:0]    okc;
    logic [CW-1:0]    failc;
    logic             ffv;
    logic [WIDTH-1:0] ffd;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  logic [4:0]       m_enum;
  logic [CW-1:0]    m_okc, m_failc;
  logic             m_ffv;
  logic [WIDTH-1:0] m_ffd;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, req, req, $time);
    end
  endtask

  task automatic model_reset();
    m_enum = 5'd16; m_okc = '0; m_failc = '0; m_ffv = 1'b0; m_ffd = '0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst = 1'b1;
    model_reset();
    #3;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Drive one word, wait (bounded) for acceptance, then record the expected result.
  task automatic send(input int v);
    int   budget;
    logic legal;
    logic [31:0] vb;
    exp_t e;
    in_valid = 1'b1;
    in_data  = v;
    budget   = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      budget++;
      if (budget > 20) begin
        check("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    vb    = v;
    legal = (v == 10) || (v == 11) || (v == 16);
    if (legal) m_enum = vb[4:0];
    if (clear) begin
      m_okc = '0; m_failc = '0; m_ffv = 1'b0;
    end else if (legal) begin
      if (m_okc != 4'd15) m_okc = m_okc + 4'd1;
    end else begin
      if (m_failc != 4'd15) m_failc = m_failc + 4'd1;
      if (!m_ffv) begin m_ffv = 1'b1; m_ffd = vb; end
    end
    e.ok = legal; e.en = m_enum; e.okc = m_okc; e.failc = m_failc; e.ffv = m_ffv; e.ffd = m_ffd;
    exp_q.push_back(e);
    #1;
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_output", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_out_ok", {31'd0, out_ok}, {31'd0, e.ok});
        check("sb_out_enum", {27'd0, out_enum}, {27'd0, e.en});
        check("sb_ok_count", {28'd0, ok_count}, {28'd0, e.okc});
        check("sb_fail_count", {28'd0, fail_count}, {28'd0, e.failc});
        check("sb_ff_valid", {31'd0, first_fail_valid}, {31'd0, e.ffv});
        check("sb_ff_data", first_fail_data, e.ffd);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    // Reset values, sampled while reset is held.
    rst = 1'b1;
    #2;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_ok", {31'd0, out_ok}, 32'd0);
    check("rst_out_enum", {27'd0, out_enum}, 32'd16);
    check("rst_ok_count", {28'd0, ok_count}, 32'd0);
    check("rst_fail_count", {28'd0, fail_count}, 32'd0);
    check("rst_ff_valid", {31'd0, first_fail_valid}, 32'd0);
    check("rst_ff_data", first_fail_data, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;

    // First illegal word.
    out_ready = 1'b1;
    send(1);
    @(negedge clk);
    check("t1_fail_count", {28'd0, fail_count}, 32'd1);
    check("t1_ff_data", first_fail_data, 32'd1);
    check("t1_out_enum", {27'd0, out_enum}, 32'd16);

    // Clear stats alone, then stream 0..17.
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk);
    m_okc = '0; m_failc = '0; m_ffv = 1'b0;
    #1;
    clear = 1'b0;
    for (int i = 0; i <= 17; i++) send(i);
    @(negedge clk);
    check("stream_ok_count", {28'd0, ok_count}, 32'd3);
    check("stream_fail_count", {28'd0, fail_count}, 32'd15);
    check("stream_ff_data", first_fail_data, 32'd0);
    check("stream_out_enum", {27'd0, out_enum}, 32'd16);

    // Values that would alias under 5-bit truncation.
    do_reset();
    send(11);
    send(42);
    send(-22);
    send(26);
    @(negedge clk);
    check("alias_fail_count", {28'd0, fail_count}, 32'd3);
    check("alias_out_enum", {27'd0, out_enum}, 32'd11);
    check("alias_ff_data", first_fail_data, 32'd42);

    // Backpressure: 11 held, 16 waits three cycles.
    do_reset();
    send(11);
    out_ready = 1'b0;
    fork
      send(16);
      begin
        repeat (3) begin
          @(negedge clk);
          check("bp_in_ready", {31'd0, in_ready}, 32'd0);
          check("bp_out_enum", {27'd0, out_enum}, 32'd11);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    @(negedge clk);
    check("bp_out_enum_after", {27'd0, out_enum}, 32'd16);
    check("bp_out_valid_after", {31'd0, out_valid}, 32'd1);

    // Saturating fail burst, then clear together with an accept of 10.
    do_reset();
    for (int i = 0; i < 20; i++) send(100 + i);
    @(negedge clk);
    check("sat_fail_count", {28'd0, fail_count}, 32'd15);
    check("sat_ff_data", first_fail_data, 32'd100);
    @(posedge clk); #1;
    clear = 1'b1;
    send(10);
    clear = 1'b0;
    @(negedge clk);
    check("clr_ok_count", {28'd0, ok_count}, 32'd0);
    check("clr_fail_count", {28'd0, fail_count}, 32'd0);
    check("clr_ff_valid", {31'd0, first_fail_valid}, 32'd0);
    check("clr_out_enum", {27'd0, out_enum}, 32'd10);
    check("clr_ff_data_kept", first_fail_data, 32'd100);

    // Asynchronous reset while a result is held.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(11);
    check("ar_pre_out_valid", {31'd0, out_valid}, 32'd1);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check("ar_out_valid", {31'd0, out_valid}, 32'd0);
    check("ar_out_ok", {31'd0, out_ok}, 32'd0);
    check("ar_out_enum", {27'd0, out_enum}, 32'd16);
    check("ar_ok_count", {28'd0, ok_count}, 32'd0);
    check("ar_in_ready", {31'd0, in_ready}, 32'd1);
    #2;
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(11);
    @(negedge clk);
    check("ar_next_ok_count", {28'd0, ok_count}, 32'd1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("sb_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/enum_cast_checker.md
# enum_cast_checker

Registered validation stage that receives a stream of integer words and casts each one to the three-member enum {TEN=10, ELEVEN=11, SIXTEEN=16} with `$cast` semantics.

- A legal value updates the held enum; an illegal value leaves it unchanged and is flagged.
- It sits directly downstream of an integer producer, such as a cycle counter or decoded field.
- It feeds enum-typed consumers through a one-deep valid/ready output register.
- It also keeps saturating pass/fail statistics and captures the first failing value for debug.

## Interface
- `WIDTH`, default 32: input word width. Signed; minimum 6.
- `CNT_W`, default 16: width of the pass and fail counters.

- `clk` input 1: clock; all logic is on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `clear` input 1: synchronous clear of the statistics (counters and first-fail capture).
- `in_valid` input 1: upstream word valid.
- `in_ready` output 1: stage can accept a word.
- `in_data` input WIDTH: signed value to cast.
- `out_valid` output 1: result valid.
- `out_ready` input 1: downstream accepts the result.
- `out_ok` output 1: 1 = cast succeeded, 0 = illegal value.
- `out_enum` output 5: held enum value, one of 10, 11 or 16.
- `ok_count` output CNT_W: number of successful casts, saturating.
- `fail_count` output CNT_W: number of failed casts, saturating.
- `first_fail_valid` output 1: a failure has been captured since reset/clear.
- `first_fail_data` output WIDTH: `in_data` of the first failure.

## Operation
- Accept condition: `in_valid && in_ready`.
- `in_ready = !out_valid || out_ready`. This is combinational and allows full throughput.
- Legality uses a full-width signed compare: `in_data` must be exactly 10, 11 or 16.
  - 42, 26 and -22 are illegal (no truncation to 5 bits).
  - With X/Z inputs, `out_ok` is 0.
- On accept:
  - `out_valid` <= 1 and `out_ok` <= legal.
  - If legal, `out_enum` <= `in_data[4:0]`; if illegal, `out_enum` keeps its prior value.
- Output handshake:
  - Result is consumed when `out_valid && out_ready`.
  - If no new accept occurs in that cycle, `out_valid` <= 0.
  - `out_ok` and `out_enum` hold their values while `out_valid` = 1 and `out_ready` = 0.
- Counters:
  - `ok_count` increments on a legal accept; `fail_count` increments on an illegal accept.
  - Both stick at 2^CNT_W-1.
- First-fail capture: on an illegal accept with `first_fail_valid` = 0, set `first_fail_valid` and latch `first_fail_data`. Later failures do not overwrite it.
- `clear`:
  - Zeroes both counters and `first_fail_valid`.
  - Leaves `first_fail_data`, `out_enum` and the output register untouched.
  - `clear` and an accept in the same cycle: the accept still updates the output register and `out_enum`, but clear wins for the statistics. That item is neither counted nor captured.

## Timing
- Reset values:
  - `out_valid` = 0, `out_ok` = 0, `out_enum` = 16.
  - `ok_count` = 0, `fail_count` = 0.
  - `first_fail_valid` = 0, `first_fail_data` = 0.
- `in_ready` = 1 during and after reset.
- Latency: 1 cycle from accept to `out_valid`/`out_ok`/`out_enum`. Statistics update on the same edge.
- Throughput: 1 word/cycle while `out_ready` = 1.
- Backpressure: with `out_valid` = 1 and `out_ready` = 0, `in_ready` = 0 and no accept occurs.
- Simultaneous output consume and new accept: the register is overwritten with the new result and `out_valid` stays 1.
- Reset mid-stream: asynchronous assertion forces all reset values immediately. A word in flight is dropped and not counted.
- There are no combinational paths from `in_data` to any output.

## Test plan
- Reset, then `in_data` = 1 with `out_ready` = 1 -> next cycle `out_valid` = 1, `out_ok` = 0, `out_enum` = 16, `fail_count` = 1, `first_fail_data` = 1.
- Stream 0..17, one per cycle, with `out_ready` = 1 -> `out_ok` = 1 only for 10, 11 and 16.
  - `out_enum` is 16 through value 9, then 10, then 11 for values 11..15, then 16 for 16..17.
  - Final `ok_count` = 3, `fail_count` = 15, `first_fail_data` = 0.
- Send 42, -22 and 26 -> all give `out_ok` = 0, `out_enum` unchanged, `fail_count` +3.
- Accept 11, then hold `out_ready` = 0 for 3 cycles while `in_valid` = 1 with 16 -> `in_ready` = 0 for those 3 cycles.
  - `out_enum` stays 11.
  - Releasing `out_ready` accepts 16 the same cycle; `out_enum` = 16 one cycle later.
- Cast-failure burst with `CNT_W` = 4: 20 illegal words -> `fail_count` saturates at 15.
  - Then `clear` in the same cycle as accepting 10 -> counters read 0, `first_fail_valid` = 0, `out_enum` = 10.
- Assert `rst` asynchronously mid-stream with `out_valid` = 1 -> all outputs take their reset values before the next clock edge. The next accepted 11 yields `ok_count` = 1.
